// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath: drives every datapath mux and enable, one step per clock.
// Optional MULTICYCLE_WAIT_STATE_EN adds a MemReady input that stretches the memory states.
module multicycle_control #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef MULTICYCLE_WAIT_STATE_EN
  input  logic       MemReady,
`endif
  input  logic [5:0] OP,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Retire,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    HALT      = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e state_q, state_d;
  logic   memDone;

`ifdef MULTICYCLE_WAIT_STATE_EN
  assign memDone = MemReady;
`else
  assign memDone = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     if (memDone) state_d = DECODE;
      DECODE: begin
        case (OP)
          OP_LW, OP_SW:             state_d = MEM_ADDR;
          OP_RTYPE:                 state_d = R_EXEC;
          OP_BEQ, OP_BNE:           state_d = BRANCH;
          OP_J:                     state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = I_EXEC;
          default: begin
            if (ILLEGAL_HALT) state_d = HALT;
            else              state_d = FETCH;
          end
        endcase
      end
      MEM_ADDR:  state_d = (OP == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (memDone) state_d = MEM_WB;
      MEM_WB:    state_d = FETCH;
      MEM_WRITE: if (memDone) state_d = FETCH;
      R_EXEC:    state_d = R_WB;
      R_WB:      state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JUMP:      state_d = FETCH;
      I_EXEC:    state_d = I_WB;
      I_WB:      state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end

  // Mostly Moore; DECODE, BRANCH, I_EXEC and the memory waits also look at OP/Zero/MemReady.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 3'b000;
    PCSource = 2'b00;
    Retire   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = memDone;
        PCWrite = memDone;
        ALUSrcB = 2'b01;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (OP)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J,
          OP_ADDI, OP_ANDI, OP_ORI: Retire = 1'b0;
          default:                  Retire = ~ILLEGAL_HALT;
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Retire   = memDone;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b111;
      end
      R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'b01;
        Retire   = 1'b1;
        PCWrite  = ((OP == OP_BEQ) & Zero) | ((OP == OP_BNE) & ~Zero);
      end
      JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
        Retire   = 1'b1;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OP)
          OP_ANDI: ALUOp = 3'b011;
          OP_ORI:  ALUOp = 3'b010;
          default: ALUOp = 3'b000;
        endcase
      end
      I_WB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state_q;

endmodule
